// File: rtl/func_arb_seq.sv
// func_arb_seq
// Shares one combinational 4-bit function unit between two requesters (A, B).
// It also runs a 16-code self-test sweep that folds every function-unit result
// into an 8-bit rotate/XOR signature.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   a_req/a_x    requester A level request and operand; a_ack is A's grant pulse
//   b_req/b_x    requester B level request and operand; b_ack is B's grant pulse
//   fu_x         registered operand driven to the shared function unit
//   fu_y         function unit result (combinational from fu_x)
//   res_y        registered result of the last requester operation
//   res_vld      one-cycle pulse, res_y/res_id valid
//   res_id       owner of res_y (0 = A, 1 = B)
//   sweep_start  level request for a self-test sweep (sampled only in IDLE)
//   sweep_busy   high for the 16 sweep cycles
//   sweep_done   one-cycle pulse when the final signature is presented
//   sweep_sig    sweep signature, held until the next sweep starts
module func_arb_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic [3:0] a_x,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [3:0] b_x,
    output logic       b_ack,
    output logic [3:0] fu_x,
    input  logic [3:0] fu_y,
    output logic [3:0] res_y,
    output logic       res_vld,
    output logic       res_id,
    input  logic       sweep_start,
    output logic       sweep_busy,
    output logic       sweep_done,
    output logic [7:0] sweep_sig
);

    localparam int DATA_W = 4;
    localparam int SIG_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [DATA_W-1:0]   fu_x_q,   fu_x_d;
    logic [DATA_W-1:0]   res_y_q,  res_y_d;
    logic                res_id_q, res_id_d;
    logic                res_vld_q, res_vld_d;
    logic                a_ack_q,  a_ack_d;
    logic                b_ack_q,  b_ack_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [SIG_W-1:0]    sig_q,    sig_d;
    logic [DATA_W-1:0]   cnt_q,    cnt_d;
    // Owner of the operation currently in EXEC (0 = A, 1 = B).
    logic                gnt_q,    gnt_d;
    // Round-robin pointer: 1 when B received the most recent grant.
    logic                last_b_q, last_b_d;

    function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], v[SIG_W-1]};
    endfunction

    function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] sig,
                                                  input logic [DATA_W-1:0] y);
        return rotl1(sig) ^ {{(SIG_W-DATA_W){1'b0}}, y};
    endfunction

    always_comb begin
        state_d   = state_q;
        fu_x_d    = fu_x_q;
        res_y_d   = res_y_q;
        res_id_d  = res_id_q;
        res_vld_d = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_b_d  = last_b_q;

        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    // Sweep wins over pending requests; they stay un-acked.
                    state_d = SWEEP;
                    cnt_d   = '0;
                    sig_d   = '0;
                    fu_x_d  = '0;
                    busy_d  = 1'b1;
                end else if (a_req || b_req) begin
                    // On a tie, serve whoever did not get the last grant.
                    if (a_req && (!b_req || last_b_q)) begin
                        gnt_d   = 1'b0;
                        fu_x_d  = a_x;
                        a_ack_d = 1'b1;
                    end else begin
                        gnt_d   = 1'b1;
                        fu_x_d  = b_x;
                        b_ack_d = 1'b1;
                    end
                    last_b_d = gnt_d;
                    state_d  = EXEC;
                end
            end

            EXEC: begin
                // Ack is visible during this cycle; capture the unit's result.
                res_y_d   = fu_y;
                res_id_d  = gnt_q;
                res_vld_d = 1'b1;
                state_d   = IDLE;
            end

            SWEEP: begin
                sig_d  = sig_fold(sig_q, fu_y);
                cnt_d  = cnt_q + 1'b1;
                fu_x_d = fu_x_q + 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fu_x_q    <= '0;
            res_y_q   <= '0;
            res_id_q  <= 1'b0;
            res_vld_q <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sig_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            last_b_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            fu_x_q    <= fu_x_d;
            res_y_q   <= res_y_d;
            res_id_q  <= res_id_d;
            res_vld_q <= res_vld_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_b_q  <= last_b_d;
        end
    end

    assign fu_x       = fu_x_q;
    assign res_y      = res_y_q;
    assign res_id     = res_id_q;
    assign res_vld    = res_vld_q;
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign sweep_sig  = sig_q;

endmodule

// File: tb/tb_func_arb_seq.sv
module tb_func_arb_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0;
    logic [3:0] a_x = 4'h0;
    logic       a_ack;
    logic       b_req = 1'b0;
    logic [3:0] b_x = 4'h0;
    logic       b_ack;
    logic [3:0] fu_x;
    logic [3:0] fu_y;
    logic [3:0] res_y;
    logic       res_vld;
    logic       res_id;
    logic       sweep_start = 1'b0;
    logic       sweep_busy;
    logic       sweep_done;
    logic [7:0] sweep_sig;

    int errors = 0;
    int checks = 0;

    func_arb_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req       (a_req),
        .a_x         (a_x),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_x         (b_x),
        .b_ack       (b_ack),
        .fu_x        (fu_x),
        .fu_y        (fu_y),
        .res_y       (res_y),
        .res_vld     (res_vld),
        .res_id      (res_id),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_sig   (sweep_sig)
    );

    // Function unit model: bitwise invert.
    assign fu_y = ~fu_x;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".fu_x"},    {4'h0, fu_x},       8'h00);
        chk({tag, ".res_y"},   {4'h0, res_y},      8'h00);
        chk({tag, ".res_id"},  {7'h0, res_id},     8'h00);
        chk({tag, ".res_vld"}, {7'h0, res_vld},    8'h00);
        chk({tag, ".acks"},    {6'h0, a_ack, b_ack}, 8'h00);
        chk({tag, ".busy"},    {7'h0, sweep_busy}, 8'h00);
        chk({tag, ".done"},    {7'h0, sweep_done}, 8'h00);
        chk({tag, ".sig"},     sweep_sig,          8'h00);
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // Single A request, operand 3 -> result C
        a_req = 1'b1; a_x = 4'h3;
        tick();
        chk("single.a_ack", {7'h0, a_ack}, 8'h01);
        chk("single.b_ack", {7'h0, b_ack}, 8'h00);
        chk("single.fu_x",  {4'h0, fu_x},  8'h03);
        chk("single.vld_early", {7'h0, res_vld}, 8'h00);
        a_req = 1'b0;
        tick();
        chk("single.a_ack_drop", {7'h0, a_ack}, 8'h00);
        chk("single.res_vld", {7'h0, res_vld}, 8'h01);
        chk("single.res_y",   {4'h0, res_y},   8'h0C);
        chk("single.res_id",  {7'h0, res_id},  8'h00);
        tick();
        chk("single.vld_pulse", {7'h0, res_vld}, 8'h00);
        chk("single.fu_x_hold", {4'h0, fu_x},    8'h03);

        // Tie from reset: A first, then B
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        a_req = 1'b1; a_x = 4'h1;
        b_req = 1'b1; b_x = 4'h2;
        tick();
        chk("tie.a_ack", {6'h0, a_ack, b_ack}, 8'h02);
        a_req = 1'b0;
        tick();
        chk("tie.resA_vld", {7'h0, res_vld}, 8'h01);
        chk("tie.resA_y",   {4'h0, res_y},   8'h0E);
        chk("tie.resA_id",  {7'h0, res_id},  8'h00);
        chk("tie.gap_acks", {6'h0, a_ack, b_ack}, 8'h00);
        tick();
        chk("tie.b_ack", {6'h0, a_ack, b_ack}, 8'h01);
        b_req = 1'b0;
        tick();
        chk("tie.resB_vld", {7'h0, res_vld}, 8'h01);
        chk("tie.resB_y",   {4'h0, res_y},   8'h0D);
        chk("tie.resB_id",  {7'h0, res_id},  8'h01);

        // Back-to-back ties: alternate A,B,A,B (last grant was B)
        a_req = 1'b1; a_x = 4'h5;
        b_req = 1'b1; b_x = 4'h9;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d.acks", k), {6'h0, a_ack, b_ack},
                (k % 2 == 0) ? 8'h02 : 8'h01);
            if (k == 3) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            tick();
            chk($sformatf("rr%0d.vld", k), {7'h0, res_vld}, 8'h01);
            chk($sformatf("rr%0d.res_y", k), {4'h0, res_y},
                (k % 2 == 0) ? 8'h0A : 8'h06);
            chk($sformatf("rr%0d.res_id", k), {7'h0, res_id},
                (k % 2 == 0) ? 8'h00 : 8'h01);
            chk($sformatf("rr%0d.idle_acks", k), {6'h0, a_ack, b_ack}, 8'h00);
        end

        // Sweep with B request raised mid-sweep
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                b_req = 1'b1; b_x = 4'h4;
            end
            chk($sformatf("sw%0d.busy", i), {7'h0, sweep_busy}, 8'h01);
            chk($sformatf("sw%0d.fu_x", i), {4'h0, fu_x}, i[7:0]);
            chk($sformatf("sw%0d.quiet", i),
                {4'h0, sweep_done, res_vld, a_ack, b_ack}, 8'h00);
            chk($sformatf("sw%0d.res_hold", i), {3'h0, res_id, res_y}, 8'h16);
            tick();
        end
        chk("sweep.busy_end", {7'h0, sweep_busy}, 8'h00);
        chk("sweep.done",     {7'h0, sweep_done}, 8'h01);
        chk("sweep.sig",      sweep_sig,          8'hFF);
        chk("sweep.no_b_ack", {7'h0, b_ack},      8'h00);
        tick();
        chk("sweep.done_pulse", {7'h0, sweep_done}, 8'h00);
        chk("sweep.sig_hold",   sweep_sig,          8'hFF);
        chk("sweep.b_ack",      {6'h0, a_ack, b_ack}, 8'h01);
        b_req = 1'b0;
        tick();
        chk("sweep.b_res", {2'h0, res_vld, res_id, res_y}, 8'h3B);

        // Reset in the 8th sweep cycle
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort.fu_x_pre", {4'h0, fu_x}, 8'h07);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort.no_done", {6'h0, sweep_done, sweep_busy}, 8'h00);

        // Fresh sweep after the aborted one
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("resweep.done", {6'h0, sweep_done, sweep_busy}, 8'h02);
        chk("resweep.sig",  sweep_sig, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
